// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared types and constants for the reset sequencer
//
// Contents:
//   state_e  : sequencer FSM states
//   LOSS_W   : width of the lock-loss event counter
//   sat_inc  : saturating increment for the lock-loss counter
package reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        GAP       = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam int LOSS_W = 8;

    function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
        return (v == {LOSS_W{1'b1}}) ? v : v + LOSS_W'(1);
    endfunction

endpackage

// File: rtl/reset_seq_sync2.sv
// rtl/reset_seq_sync2.sv - two-flop synchronizer, async active-high reset to 0
//
// Ports:
//   clk  in  destination clock
//   rst  in  asynchronous active-high reset, clears both flops
//   d_i  in  asynchronous input
//   q_o  out input synchronized to clk (two-cycle latency)
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/reset_seq.sv
// rtl/reset_seq.sv - staged reset sequencer driven by PLL lock
//
// Waits for a filtered, stable PLL lock, holds both resets for a while,
// releases the peripheral reset first and the core reset STAGE_GAP cycles
// later. Any loss of lock after the filter restarts the sequence and is
// counted. Optional user reset button when RESET_BTN_EN is defined.
//
// Parameters:
//   LOCK_FILTER   consecutive high synchronized lock samples before HOLD
//   HOLD_CYCLES   cycles spent in HOLD (both resets asserted)
//   STAGE_GAP     cycles between peripheral and core reset release
//   BTN_DEBOUNCE  stable-high btn cycles for a press (RESET_BTN_EN only)
//
// Ports:
//   clk         in   32 MHz PLL output clock
//   rst         in   asynchronous active-high reset
//   locked      in   PLL lock, asynchronous to clk
//   btn         in   user reset button, asynchronous (RESET_BTN_EN only)
//   rst_periph  out  active-high peripheral/memory reset
//   rst_core    out  active-high CPU core reset
//   ready       out  system running
//   lock_loss   out  saturating count of lock-loss events
//
// Macro: RESET_BTN_EN
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int unsigned LOCK_FILTER  = 16,
    parameter int unsigned HOLD_CYCLES  = 1024,
    parameter int unsigned STAGE_GAP    = 16,
    parameter int unsigned BTN_DEBOUNCE = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              locked,
`ifdef RESET_BTN_EN
    input  logic              btn,
`endif
    output logic              rst_periph,
    output logic              rst_core,
    output logic              ready,
    output logic [LOSS_W-1:0] lock_loss
);

    localparam int FILT_W = $clog2(LOCK_FILTER + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int GAP_W  = $clog2(STAGE_GAP + 1);

    // HOLD and GAP leave on the last cycle of their stay; the filter leaves
    // on the sample after the count has reached LOCK_FILTER.
    localparam logic [FILT_W-1:0] FILT_TC = FILT_W'(LOCK_FILTER);
    localparam logic [HOLD_W-1:0] HOLD_TC = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_TC  = GAP_W'(STAGE_GAP - 1);

    if (LOCK_FILTER < 1 || HOLD_CYCLES < 1 || STAGE_GAP < 1 || BTN_DEBOUNCE < 1) begin : g_param_check
        $error("reset_seq: timing parameters must be at least 1");
    end

    logic locked_s;

    sync2 u_sync_locked (
        .clk (clk),
        .rst (rst),
        .d_i (locked),
        .q_o (locked_s)
    );

    logic press;

`ifdef RESET_BTN_EN
    localparam int BTN_W = $clog2(BTN_DEBOUNCE + 1);
    localparam logic [BTN_W-1:0] BTN_TC = BTN_W'(BTN_DEBOUNCE);

    logic             btn_s;
    logic [BTN_W-1:0] btn_cnt_q;
    logic [BTN_W-1:0] btn_cnt_d;

    sync2 u_sync_btn (
        .clk (clk),
        .rst (rst),
        .d_i (btn),
        .q_o (btn_s)
    );

    // Counter saturates at BTN_TC, so the press fires only on the cycle it
    // reaches the threshold; a low sample re-arms by clearing it.
    always_comb begin
        btn_cnt_d = btn_cnt_q;
        press     = 1'b0;
        if (!btn_s) begin
            btn_cnt_d = '0;
        end else if (btn_cnt_q != BTN_TC) begin
            btn_cnt_d = btn_cnt_q + BTN_W'(1);
            press     = (btn_cnt_q == BTN_TC - BTN_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_cnt_q <= '0;
        end else begin
            btn_cnt_q <= btn_cnt_d;
        end
    end
`else
    assign press = 1'b0;
`endif

    state_e              state_q;
    state_e              state_d;
    logic [FILT_W-1:0]   filt_q;
    logic [FILT_W-1:0]   filt_d;
    logic [HOLD_W-1:0]   hold_q;
    logic [HOLD_W-1:0]   hold_d;
    logic [GAP_W-1:0]    gap_q;
    logic [GAP_W-1:0]    gap_d;
    logic [LOSS_W-1:0]   loss_q;
    logic [LOSS_W-1:0]   loss_d;
    logic                rst_periph_q;
    logic                rst_periph_d;
    logic                rst_core_q;
    logic                rst_core_d;
    logic                ready_q;
    logic                ready_d;

    // Counters default to zero every cycle, so any state change (including
    // lock loss and button presses) leaves them cleared on entry.
    always_comb begin
        state_d = state_q;
        filt_d  = '0;
        hold_d  = '0;
        gap_d   = '0;
        loss_d  = loss_q;

        unique case (state_q)
            WAIT_LOCK: begin
                if (locked_s) begin
                    if (filt_q == FILT_TC) begin
                        state_d = HOLD;
                    end else begin
                        filt_d = filt_q + FILT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    loss_d  = sat_inc(loss_q);
                end else if (hold_q == HOLD_TC) begin
                    state_d = GAP;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            GAP: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    loss_d  = sat_inc(loss_q);
                end else if (press) begin
                    state_d = HOLD;
                end else if (gap_q == GAP_TC) begin
                    state_d = RUN;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    loss_d  = sat_inc(loss_q);
                end else if (press) begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state register, with no decode glitches downstream.
    always_comb begin
        rst_periph_d = (state_d == WAIT_LOCK) || (state_d == HOLD);
        rst_core_d   = (state_d != RUN);
        ready_d      = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= WAIT_LOCK;
            filt_q       <= '0;
            hold_q       <= '0;
            gap_q        <= '0;
            loss_q       <= '0;
            rst_periph_q <= 1'b1;
            rst_core_q   <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            filt_q       <= filt_d;
            hold_q       <= hold_d;
            gap_q        <= gap_d;
            loss_q       <= loss_d;
            rst_periph_q <= rst_periph_d;
            rst_core_q   <= rst_core_d;
            ready_q      <= ready_d;
        end
    end

    assign rst_periph = rst_periph_q;
    assign rst_core   = rst_core_q;
    assign ready      = ready_q;
    assign lock_loss  = loss_q;

endmodule

// File: tb/tb_reset_seq.sv
// tb/tb_reset_seq.sv - self-checking bench for reset_seq
module tb_reset_seq;

    localparam int F = 4;
    localparam int H = 8;
    localparam int G = 2;
    localparam int D = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       locked = 1'b0;
    logic       btn = 1'b0;
    logic       rst_periph;
    logic       rst_core;
    logic       ready;
    logic [7:0] lock_loss;

    always #16 clk = ~clk;

    reset_seq #(
        .LOCK_FILTER  (F),
        .HOLD_CYCLES  (H),
        .STAGE_GAP    (G),
        .BTN_DEBOUNCE (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .locked     (locked),
`ifdef RESET_BTN_EN
        .btn        (btn),
`endif
        .rst_periph (rst_periph),
        .rst_core   (rst_core),
        .ready      (ready),
        .lock_loss  (lock_loss)
    );

    int checks = 0;
    int fails  = 0;
    int edge_no = 0;

    // Reference model: inputs become visible two edges after being sampled;
    // m_since counts edges since the resets were (re)held after stable lock,
    // -1 while still waiting for lock.
    logic [1:0] m_lsh;
    logic [1:0] m_bsh;
    int         m_run;
    int         m_brun;
    int         m_since;
    logic [7:0] m_loss;
    logic       m_p;
    logic       m_c;
    logic       m_r;

    task automatic model_reset();
        m_lsh   = 2'b00;
        m_bsh   = 2'b00;
        m_run   = 0;
        m_brun  = 0;
        m_since = -1;
        m_loss  = 8'd0;
        m_p     = 1'b1;
        m_c     = 1'b1;
        m_r     = 1'b0;
    endtask

    task automatic model_edge(input logic l, input logic b);
        logic vis_l;
        logic vis_b;
        logic press;
        vis_l = m_lsh[1];
        vis_b = m_bsh[1];
        m_lsh = {m_lsh[0], l};
        m_bsh = {m_bsh[0], b};
        press = 1'b0;
        if (!vis_b) m_brun = 0;
        else if (m_brun < D) begin
            m_brun++;
            press = (m_brun == D);
        end
        if (m_since < 0) begin
            if (vis_l) begin
                m_run++;
                if (m_run == F + 1) begin
                    m_since = 0;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
        end else if (!vis_l) begin
            m_since = -1;
            m_run   = 0;
            if (m_loss != 8'd255) m_loss++;
        end else if (press && m_since >= H) begin
            m_since = 0;
        end else if (m_since < H + G) begin
            m_since++;
        end
        if (m_since < 0) begin
            m_p = 1'b1; m_c = 1'b1; m_r = 1'b0;
        end else begin
            m_p = (m_since < H);
            m_c = (m_since < H + G);
            m_r = !m_c;
        end
    endtask

    task automatic tick(input logic l, input logic b);
        locked = l;
        btn    = b;
        @(posedge clk);
        model_edge(l, b);
        edge_no++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        locked = 1'b0;
        btn    = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        edge_no = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #5 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({rst_periph, rst_core, ready, lock_loss} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
            fails++;
            $display("FAIL reset_async: got p=%b c=%b r=%b loss=%0d, want p=1 c=1 r=0 loss=0",
                     rst_periph, rst_core, ready, lock_loss);
        end
        locked = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({rst_periph, rst_core, ready, lock_loss} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
            fails++;
            $display("FAIL reset_held: got p=%b c=%b r=%b loss=%0d, want p=1 c=1 r=0 loss=0",
                     rst_periph, rst_core, ready, lock_loss);
        end
    endtask

    task automatic test_startup();
        int fall_p;
        int fall_c;
        int rise_r;
        fall_p = -1; fall_c = -1; rise_r = -1;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if ({rst_periph, rst_core, ready, lock_loss} !== {m_p, m_c, m_r, m_loss}) begin
                fails++;
                $display("FAIL startup e%0d: got p=%b c=%b r=%b loss=%0d, want p=%b c=%b r=%b loss=%0d",
                         edge_no - 1, rst_periph, rst_core, ready, lock_loss, m_p, m_c, m_r, m_loss);
            end
            if (fall_p < 0 && rst_periph === 1'b0) fall_p = edge_no - 1;
            if (fall_c < 0 && rst_core === 1'b0) fall_c = edge_no - 1;
            if (rise_r < 0 && ready === 1'b1) rise_r = edge_no - 1;
        end
        checks++;
        if (fall_p != 2 + F + H) begin
            fails++;
            $display("FAIL startup_periph_edge: got %0d, want %0d", fall_p, 2 + F + H);
        end
        checks++;
        if (fall_c != 2 + F + H + G || rise_r != 2 + F + H + G) begin
            fails++;
            $display("FAIL startup_core_edge: got core %0d ready %0d, want %0d", fall_c, rise_r, 2 + F + H + G);
        end
        checks++;
        if (lock_loss !== 8'd0) begin
            fails++;
            $display("FAIL startup_loss: got %0d, want 0", lock_loss);
        end
    endtask

    task automatic test_glitch();
        int g;
        int fall_p;
        for (int rep = 0; rep < 3; rep++) begin
            g = int'($urandom_range(0, F));
            fall_p = -1;
            do_reset();
            for (int i = 0; i < 30; i++) begin
                tick(edge_no != g, 1'b0);
                checks++;
                if ({rst_periph, rst_core, ready, lock_loss} !== {m_p, m_c, m_r, m_loss}) begin
                    fails++;
                    $display("FAIL glitch g%0d e%0d: got p=%b c=%b r=%b loss=%0d, want p=%b c=%b r=%b loss=%0d",
                             g, edge_no - 1, rst_periph, rst_core, ready, lock_loss, m_p, m_c, m_r, m_loss);
                end
                if (fall_p < 0 && rst_periph === 1'b0) fall_p = edge_no - 1;
            end
            checks++;
            if (fall_p != 2 + F + H + g + 1) begin
                fails++;
                $display("FAIL glitch_delay g%0d: got %0d, want %0d", g, fall_p, 2 + F + H + g + 1);
            end
        end
    endtask

    task automatic test_lock_loss();
        int n;
        bit done;
        int e0;
        int fall_p;
        int fall_c;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if ({rst_periph, rst_core, ready, lock_loss} !== {m_p, m_c, m_r, m_loss}) begin
                fails++;
                $display("FAIL loss_run e%0d: got p=%b c=%b r=%b loss=%0d, want p=%b c=%b r=%b loss=%0d",
                         edge_no - 1, rst_periph, rst_core, ready, lock_loss, m_p, m_c, m_r, m_loss);
            end
        end
        n = 0;
        done = 1'b0;
        while (!done && n < 6) begin
            tick(1'b0, 1'b0);
            n++;
            checks++;
            if ({rst_periph, rst_core, ready, lock_loss} !== {m_p, m_c, m_r, m_loss}) begin
                fails++;
                $display("FAIL loss_drop e%0d: got p=%b c=%b r=%b loss=%0d, want p=%b c=%b r=%b loss=%0d",
                         edge_no - 1, rst_periph, rst_core, ready, lock_loss, m_p, m_c, m_r, m_loss);
            end
            if (rst_periph === 1'b1 && rst_core === 1'b1 && ready === 1'b0) done = 1'b1;
        end
        checks++;
        if (!done || n > 3) begin
            fails++;
            $display("FAIL loss_latency: got %0d edges (done=%0d), want <= 3", n, done);
        end
        checks++;
        if (lock_loss !== 8'd1) begin
            fails++;
            $display("FAIL loss_count: got %0d, want 1", lock_loss);
        end
        repeat ($urandom_range(0, 2)) tick(1'b0, 1'b0);
        e0 = edge_no;
        fall_p = -1; fall_c = -1;
        for (int i = 0; i < 24; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if ({rst_periph, rst_core, ready, lock_loss} !== {m_p, m_c, m_r, m_loss}) begin
                fails++;
                $display("FAIL loss_relock e%0d: got p=%b c=%b r=%b loss=%0d, want p=%b c=%b r=%b loss=%0d",
                         edge_no - 1, rst_periph, rst_core, ready, lock_loss, m_p, m_c, m_r, m_loss);
            end
            if (fall_p < 0 && rst_periph === 1'b0) fall_p = edge_no - 1;
            if (fall_c < 0 && rst_core === 1'b0) fall_c = edge_no - 1;
        end
        checks++;
        if (fall_p != e0 + 2 + F + H || fall_c != e0 + 2 + F + H + G) begin
            fails++;
            $display("FAIL loss_relock_edges: got p %0d c %0d, want p %0d c %0d",
                     fall_p, fall_c, e0 + 2 + F + H, e0 + 2 + F + H + G);
        end
    endtask

    task automatic test_saturation();
        int hi;
        int lo;
        for (int it = 0; it < 300; it++) begin
            hi = int'($urandom_range(5, 20));
            lo = int'($urandom_range(1, 3));
            for (int k = 0; k < hi + lo; k++) begin
                tick(k < hi, 1'b0);
                checks++;
                if ({rst_periph, rst_core, ready, lock_loss} !== {m_p, m_c, m_r, m_loss}) begin
                    fails++;
                    $display("FAIL saturate it%0d e%0d: got p=%b c=%b r=%b loss=%0d, want p=%b c=%b r=%b loss=%0d",
                             it, edge_no - 1, rst_periph, rst_core, ready, lock_loss, m_p, m_c, m_r, m_loss);
                end
            end
        end
        repeat (3) tick(1'b0, 1'b0);
        checks++;
        if (lock_loss !== 8'd255) begin
            fails++;
            $display("FAIL saturate_final: got %0d, want 255", lock_loss);
        end
    endtask

    task automatic test_rst_midway();
        int n;
        int fall_p;
        n = 0;
        while (!(m_since >= 1 && m_since < H - 1) && n < 40) begin
            tick(1'b1, 1'b0);
            n++;
            checks++;
            if ({rst_periph, rst_core, ready, lock_loss} !== {m_p, m_c, m_r, m_loss}) begin
                fails++;
                $display("FAIL midrst_pre e%0d: got p=%b c=%b r=%b loss=%0d, want p=%b c=%b r=%b loss=%0d",
                         edge_no - 1, rst_periph, rst_core, ready, lock_loss, m_p, m_c, m_r, m_loss);
            end
        end
        checks++;
        if (n >= 40) begin
            fails++;
            $display("FAIL midrst_reach_hold: got timeout after %0d edges, want HOLD", n);
        end
        #5 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({rst_periph, rst_core, ready, lock_loss} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
            fails++;
            $display("FAIL midrst_async: got p=%b c=%b r=%b loss=%0d, want p=1 c=1 r=0 loss=0",
                     rst_periph, rst_core, ready, lock_loss);
        end
        locked = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        edge_no = 0;
        fall_p = -1;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if ({rst_periph, rst_core, ready, lock_loss} !== {m_p, m_c, m_r, m_loss}) begin
                fails++;
                $display("FAIL midrst_restart e%0d: got p=%b c=%b r=%b loss=%0d, want p=%b c=%b r=%b loss=%0d",
                         edge_no - 1, rst_periph, rst_core, ready, lock_loss, m_p, m_c, m_r, m_loss);
            end
            if (fall_p < 0 && rst_periph === 1'b0) fall_p = edge_no - 1;
        end
        checks++;
        if (fall_p != 2 + F + H) begin
            fails++;
            $display("FAIL midrst_periph_edge: got %0d, want %0d", fall_p, 2 + F + H);
        end
    endtask

`ifdef RESET_BTN_EN
    task automatic test_btn();
        bit   dropped;
        int   b0;
        int   len;
        int   hit;
        int   fall_p;
        int   fall_c;
        do_reset();
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
        dropped = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, i < D - 1);
            checks++;
            if ({rst_periph, rst_core, ready, lock_loss} !== {m_p, m_c, m_r, m_loss}) begin
                fails++;
                $display("FAIL btn_short e%0d: got p=%b c=%b r=%b loss=%0d, want p=%b c=%b r=%b loss=%0d",
                         edge_no - 1, rst_periph, rst_core, ready, lock_loss, m_p, m_c, m_r, m_loss);
            end
            if (ready !== 1'b1) dropped = 1'b1;
        end
        checks++;
        if (dropped) begin
            fails++;
            $display("FAIL btn_short_effect: got ready drop, want ready held 1");
        end
        for (int rep = 0; rep < 2; rep++) begin
            b0 = edge_no;
            len = int'($urandom_range(D, D + 4));
            hit = -1; fall_p = -1; fall_c = -1;
            for (int i = 0; i < 26; i++) begin
                tick(1'b1, i < len);
                checks++;
                if ({rst_periph, rst_core, ready, lock_loss} !== {m_p, m_c, m_r, m_loss}) begin
                    fails++;
                    $display("FAIL btn_press e%0d: got p=%b c=%b r=%b loss=%0d, want p=%b c=%b r=%b loss=%0d",
                             edge_no - 1, rst_periph, rst_core, ready, lock_loss, m_p, m_c, m_r, m_loss);
                end
                if (hit < 0 && rst_core === 1'b1) hit = edge_no - 1;
                if (hit >= 0 && fall_p < 0 && rst_periph === 1'b0) fall_p = edge_no - 1;
                if (hit >= 0 && fall_c < 0 && rst_core === 1'b0) fall_c = edge_no - 1;
            end
            checks++;
            if (hit != b0 + 1 + D || fall_p != b0 + 1 + D + H || fall_c != b0 + 1 + D + H + G) begin
                fails++;
                $display("FAIL btn_press_edges: got hold %0d p %0d c %0d, want %0d %0d %0d",
                         hit, fall_p, fall_c, b0 + 1 + D, b0 + 1 + D + H, b0 + 1 + D + H + G);
            end
            checks++;
            if (lock_loss !== 8'd0) begin
                fails++;
                $display("FAIL btn_loss: got %0d, want 0", lock_loss);
            end
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_startup();
        test_glitch();
        test_lock_loss();
        test_saturation();
        test_rst_midway();
`ifdef RESET_BTN_EN
        test_btn();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
